// File: rtl/char_template_match_if.sv
// char_template_match_if: buffer/template read bus plus start/busy/done/result handshake; master = matcher side, slave = RAM/ROM and control side
interface char_template_match_if #(
  parameter int ADDR_W = 15,
  parameter int TIDX_W = 6
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] buf_addr;
  logic              buf_data;
  logic [TIDX_W-1:0] tpl_sel;
  logic [ADDR_W-1:0] tpl_addr;
  logic              tpl_data;
  logic [TIDX_W-1:0] best_idx;
  logic [ADDR_W-1:0] best_score;
  modport master (
    input  start, buf_data, tpl_data,
    output busy, done, buf_addr, tpl_sel, tpl_addr, best_idx, best_score
  );
  modport slave (
    output start, buf_data, tpl_data,
    input  busy, done, buf_addr, tpl_sel, tpl_addr, best_idx, best_score
  );
endinterface

// File: rtl/char_template_match.sv
// char_template_match: scores NUM_TEMPLATES 1-bit templates against the character buffer (clk, sync active-high rst, bus = start/busy/done, buf/tpl reads with 1-cycle latency, best_idx/best_score result)
module char_template_match #(
  parameter int IMG_W         = 200,
  parameter int IMG_H         = 105,
  parameter int ADDR_W        = 15,
  parameter int NUM_TEMPLATES = 36,
  parameter int TIDX_W        = 6
) (
  input logic                   clk,
  input logic                   rst,
  char_template_match_if.master bus
);
  localparam int PIX_COUNT = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_COUNT - 1);
  localparam logic [TIDX_W-1:0] LAST_TPL  = TIDX_W'(NUM_TEMPLATES - 1);
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, NEXT, FINISH} state_t;
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] score;
  logic [ADDR_W-1:0] run_score;
  logic [ADDR_W-1:0] best_score;
  logic [TIDX_W-1:0] sel;
  logic [TIDX_W-1:0] run_idx;
  logic [TIDX_W-1:0] best_idx;
  logic              vld;
  logic              busy;
  logic              done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      score      <= '0;
      run_score  <= '0;
      best_score <= '0;
      sel        <= '0;
      run_idx    <= '0;
      best_idx   <= '0;
      vld        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      vld  <= state == SCAN;
      done <= 1'b0;
      if (vld && bus.buf_data == bus.tpl_data) score <= score + 1'b1;
      case (state)
        IDLE: begin
          busy <= bus.start;
          if (bus.start) begin
            state     <= SCAN;
            addr      <= '0;
            sel       <= '0;
            score     <= '0;
            run_score <= '0;
            run_idx   <= '0;
          end
        end
        SCAN: begin
          if (addr == LAST_ADDR) state <= DRAIN;
          else addr <= addr + 1'b1;
        end
        DRAIN: state <= NEXT;
        NEXT: begin
          if (score > run_score || sel == '0) begin
            run_score <= score;
            run_idx   <= sel;
          end
          if (sel == LAST_TPL) state <= FINISH;
          else begin
            sel   <= sel + 1'b1;
            addr  <= '0;
            score <= '0;
            state <= SCAN;
          end
        end
        FINISH: begin
          best_score <= run_score;
          best_idx   <= run_idx;
          done       <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.buf_addr   = addr;
  assign bus.tpl_addr   = addr;
  assign bus.tpl_sel    = sel;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.best_idx   = best_idx;
  assign bus.best_score = best_score;
endmodule

// File: tb/tb_char_template_match.sv
// tb_char_template_match: directed tests of a small 4x2/3-template matcher and a full-size 200x105/2-template matcher
module tb_char_template_match;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  char_template_match_if s_if ();
  char_template_match_if b_if ();
  char_template_match #(.IMG_W(4), .IMG_H(2), .NUM_TEMPLATES(3)) dut_s (.clk(clk), .rst(rst), .bus(s_if.master));
  char_template_match #(.NUM_TEMPLATES(2)) dut_b (.clk(clk), .rst(rst), .bus(b_if.master));
  logic [7:0] sbuf;
  logic [7:0] stpl [4];
  always @(posedge clk) begin
    s_if.buf_data <= sbuf[s_if.buf_addr[2:0]];
    s_if.tpl_data <= stpl[s_if.tpl_sel[1:0]][s_if.tpl_addr[2:0]];
    b_if.buf_data <= 1'b0;
    b_if.tpl_data <= (b_if.tpl_sel == 6'd0);
  end
  task automatic load(input logic [7:0] b, input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2);
    sbuf = b;
    stpl[0] = t0;
    stpl[1] = t1;
    stpl[2] = t2;
    stpl[3] = 8'h00;
  endtask
  task automatic kick();
    @(negedge clk) s_if.start = 1'b1;
    @(negedge clk) s_if.start = 1'b0;
  endtask
  task automatic wait_s(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (s_if.done) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({s_if.busy, s_if.done, s_if.best_idx, s_if.best_score} !== '0) begin
      bad++;
      $display("FAIL reset_status got busy=%0b done=%0b idx=%0d score=%0d want all 0", s_if.busy, s_if.done, s_if.best_idx, s_if.best_score);
    end
    total++;
    if ({s_if.buf_addr, s_if.tpl_addr, s_if.tpl_sel} !== '0) begin
      bad++;
      $display("FAIL reset_addr got buf_addr=%0d tpl_addr=%0d tpl_sel=%0d want 0", s_if.buf_addr, s_if.tpl_addr, s_if.tpl_sel);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_exact();
    int n;
    load(8'b10110010, 8'b10110101, 8'b10101101, 8'b10110010);
    kick();
    total++;
    if (s_if.busy !== 1'b1 || s_if.buf_addr !== 15'd0) begin
      bad++;
      $display("FAIL exact_start got busy=%0b buf_addr=%0d want 1/0", s_if.busy, s_if.buf_addr);
    end
    wait_s(60, n);
    total++;
    if (n !== 31) begin
      bad++;
      $display("FAIL exact_latency got %0d want 31", n);
    end
    total++;
    if (s_if.best_idx !== 6'd2 || s_if.best_score !== 15'd8 || s_if.busy !== 1'b1) begin
      bad++;
      $display("FAIL exact_result got idx=%0d score=%0d busy=%0b want 2/8/1", s_if.best_idx, s_if.best_score, s_if.busy);
    end
    @(negedge clk);
    total++;
    if (s_if.done !== 1'b0 || s_if.busy !== 1'b0 || s_if.best_idx !== 6'd2) begin
      bad++;
      $display("FAIL exact_after got done=%0b busy=%0b idx=%0d want 0/0/2", s_if.done, s_if.busy, s_if.best_idx);
    end
  endtask
  task automatic test_mid_reset();
    kick();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({s_if.busy, s_if.done, s_if.best_idx, s_if.best_score, s_if.buf_addr} !== '0) begin
      bad++;
      $display("FAIL mid_reset got busy=%0b done=%0b idx=%0d score=%0d addr=%0d want all 0", s_if.busy, s_if.done, s_if.best_idx, s_if.best_score, s_if.buf_addr);
    end
  endtask
  task automatic test_tie();
    int n;
    load(8'b10110010, 8'b10110001, 8'b01110010, 8'b10111101);
    kick();
    wait_s(60, n);
    total++;
    if (n !== 31 || s_if.best_idx !== 6'd0 || s_if.best_score !== 15'd6) begin
      bad++;
      $display("FAIL tie got n=%0d idx=%0d score=%0d want 31/0/6", n, s_if.best_idx, s_if.best_score);
    end
  endtask
  task automatic test_all_zero();
    int n;
    load(8'h00, 8'hff, 8'h00, 8'hff);
    kick();
    wait_s(60, n);
    total++;
    if (n !== 31 || s_if.best_idx !== 6'd1 || s_if.best_score !== 15'd8) begin
      bad++;
      $display("FAIL all_zero got n=%0d idx=%0d score=%0d want 31/1/8", n, s_if.best_idx, s_if.best_score);
    end
  endtask
  task automatic test_ignored_start();
    int n;
    int extra;
    load(8'b10110010, 8'b10110101, 8'b10101101, 8'b10110010);
    kick();
    repeat (12) @(negedge clk);
    s_if.start = 1'b1;
    @(negedge clk) s_if.start = 1'b0;
    wait_s(60, n);
    total++;
    if (n !== 18 || s_if.best_idx !== 6'd2 || s_if.best_score !== 15'd8) begin
      bad++;
      $display("FAIL ignored_start got n=%0d idx=%0d score=%0d want 18/2/8", n, s_if.best_idx, s_if.best_score);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_if.done || s_if.busy) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL ignored_start_rerun got %0d busy/done cycles want 0", extra);
    end
  endtask
  task automatic test_back_to_back();
    int n;
    int errs;
    logic [14:0] ea;
    logic [5:0] es;
    load(8'b10110010, 8'b10110101, 8'b10101101, 8'b10110010);
    kick();
    errs = 0;
    for (int k = 0; k < 30; k++) begin
      ea = (k % 10 < 8) ? 15'(k % 10) : 15'd7;
      es = 6'(k / 10);
      if (s_if.buf_addr !== ea || s_if.tpl_addr !== ea || s_if.tpl_sel !== es || s_if.busy !== 1'b1) begin
        errs++;
        $display("FAIL addr_seq cycle %0d got addr=%0d taddr=%0d sel=%0d want %0d/%0d", k, s_if.buf_addr, s_if.tpl_addr, s_if.tpl_sel, ea, es);
      end
      @(negedge clk);
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL addr_seq got %0d bad cycles want 0", errs);
    end
    @(negedge clk);
    total++;
    if (s_if.done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first_done got %0b want 1", s_if.done);
    end
    s_if.start = 1'b1;
    @(negedge clk) s_if.start = 1'b0;
    total++;
    if (s_if.busy !== 1'b1 || s_if.done !== 1'b0 || s_if.buf_addr !== 15'd0 || s_if.tpl_sel !== 6'd0) begin
      bad++;
      $display("FAIL b2b_restart got busy=%0b done=%0b addr=%0d sel=%0d want 1/0/0/0", s_if.busy, s_if.done, s_if.buf_addr, s_if.tpl_sel);
    end
    wait_s(60, n);
    total++;
    if (n !== 31 || s_if.best_idx !== 6'd2 || s_if.best_score !== 15'd8) begin
      bad++;
      $display("FAIL b2b_second got n=%0d idx=%0d score=%0d want 31/2/8", n, s_if.best_idx, s_if.best_score);
    end
  endtask
  task automatic test_full_size();
    int n;
    @(negedge clk) b_if.start = 1'b1;
    @(negedge clk) b_if.start = 1'b0;
    n = 0;
    for (int i = 1; i <= 50000; i++) begin
      @(negedge clk);
      if (b_if.done) begin
        n = i;
        break;
      end
    end
    total++;
    if (n !== 42005 || b_if.best_idx !== 6'd1 || b_if.best_score !== 15'd21000) begin
      bad++;
      $display("FAIL full_size got n=%0d idx=%0d score=%0d want 42005/1/21000", n, b_if.best_idx, b_if.best_score);
    end
  endtask
  initial begin
    s_if.start = 1'b0;
    b_if.start = 1'b0;
    load(8'h00, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_exact();
    test_mid_reset();
    test_tie();
    test_all_zero();
    test_ignored_start();
    test_back_to_back();
    test_full_size();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
